// File: rtl/cdc_fifo_pkg.sv
// Shared default parameters and Gray-code conversion helpers for the dual-clock FIFO.
`timescale 1ns/100ps
package cdc_fifo_pkg;

    localparam int unsigned DATA_WIDTH_DEF   = 8;
    localparam int unsigned ADDR_WIDTH_DEF   = 13;
    localparam int unsigned SYNC_STAGES_DEF  = 2;
    localparam int unsigned AFULL_MARGIN_DEF = 4;
    localparam int unsigned AEMPTY_LEVEL_DEF = 4;

    // Callers zero-extend narrower pointers to 32 bits and truncate the result.
    function automatic logic [31:0] bin2gray(input logic [31:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] gray);
        logic [31:0] bin;
        bin[31] = gray[31];
        for (int unsigned i = 31; i > 0; i--) begin
            bin[i-1] = bin[i] ^ gray[i-1];
        end
        return bin;
    endfunction

endpackage

// File: rtl/cdc_fifo_sync_bus.sv
// Multi-bit flop synchroniser, STAGES deep, cleared asynchronously; used for Gray pointers and reset release.
`timescale 1ns/100ps
module cdc_sync_bus #(
    parameter int unsigned WIDTH  = 1,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] sync_q [STAGES];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= d_i;
            for (int unsigned i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/cdc_fifo.sv
// Dual-clock FIFO: Gray-coded pointer crossing, look-ahead full/empty, per-domain reset release.
// Define CDC_FIFO_FWFT_EN for first-word-fall-through output; default is standard registered read.
`timescale 1ns/100ps
module cdc_fifo
    import cdc_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int unsigned ADDR_WIDTH   = ADDR_WIDTH_DEF,
    parameter int unsigned SYNC_STAGES  = SYNC_STAGES_DEF,
    parameter int unsigned AFULL_LEVEL  = (1 << ADDR_WIDTH) - AFULL_MARGIN_DEF,
    parameter int unsigned AEMPTY_LEVEL = AEMPTY_LEVEL_DEF
) (
    input  logic                  clk_write,
    input  logic                  clk_read,
    input  logic                  rst_n,
    input  logic                  write,
    input  logic [DATA_WIDTH-1:0] data_write,
    output logic                  full,
    output logic                  afull,
    output logic                  overflow,
    output logic [ADDR_WIDTH:0]   wr_count,
    input  logic                  read,
    output logic [DATA_WIDTH-1:0] data_read,
    output logic                  valid_read,
    output logic                  empty,
    output logic                  aempty,
    output logic                  underflow,
    output logic [ADDR_WIDTH:0]   rd_count
);

    localparam int unsigned PTR_W = ADDR_WIDTH + 1;
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C  = PTR_W'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AFULL_C  = PTR_W'(AFULL_LEVEL);
    localparam logic [ADDR_WIDTH:0] AEMPTY_C = PTR_W'(AEMPTY_LEVEL);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  w_ready;
    logic                  r_ready;
    logic [ADDR_WIDTH:0]   w_ptr_q, w_ptr_d, w_gray_q;
    logic [ADDR_WIDTH:0]   r_gray_wsync, r_ptr_wsync, wr_count_d, wr_count_q;
    logic                  full_q, afull_q, overflow_q, w_accept;

    logic [ADDR_WIDTH:0]   r_ptr_q, r_ptr_d, r_gray_q, r_cons_d;
    logic [ADDR_WIDTH:0]   w_gray_rsync, w_ptr_rsync, rd_count_d, rd_count_q;
    logic                  empty_q, aempty_q, underflow_q, valid_q, valid_d;
    logic                  r_pop, r_fetch;
    logic [DATA_WIDTH-1:0] data_q;

    cdc_sync_bus #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_wrst_sync (
        .clk_i (clk_write),
        .rst_ni(rst_n),
        .d_i   (1'b1),
        .q_o   (w_ready)
    );

    cdc_sync_bus #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_rrst_sync (
        .clk_i (clk_read),
        .rst_ni(rst_n),
        .d_i   (1'b1),
        .q_o   (r_ready)
    );

    cdc_sync_bus #(.WIDTH(PTR_W), .STAGES(SYNC_STAGES)) u_rptr_sync (
        .clk_i (clk_write),
        .rst_ni(rst_n),
        .d_i   (r_gray_q),
        .q_o   (r_gray_wsync)
    );

    cdc_sync_bus #(.WIDTH(PTR_W), .STAGES(SYNC_STAGES)) u_wptr_sync (
        .clk_i (clk_read),
        .rst_ni(rst_n),
        .d_i   (w_gray_q),
        .q_o   (w_gray_rsync)
    );

    // Write domain
    always_comb begin
        w_accept    = w_ready & write & ~full_q;
        w_ptr_d     = w_ptr_q + PTR_W'(w_accept);
        r_ptr_wsync = PTR_W'(gray2bin(32'(r_gray_wsync)));
        wr_count_d  = w_ptr_d - r_ptr_wsync;
    end

    always_ff @(posedge clk_write or negedge rst_n) begin
        if (!rst_n) begin
            w_ptr_q    <= '0;
            w_gray_q   <= '0;
            wr_count_q <= '0;
            full_q     <= 1'b0;
            afull_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            w_ptr_q    <= w_ptr_d;
            w_gray_q   <= PTR_W'(bin2gray(32'(w_ptr_d)));
            wr_count_q <= wr_count_d;
            full_q     <= ~w_ready | (wr_count_d == DEPTH_C);
            afull_q    <= w_ready & (wr_count_d >= AFULL_C);
            overflow_q <= w_ready & write & full_q;
        end
    end

    always_ff @(posedge clk_write) begin
        if (w_accept) begin
            mem[w_ptr_q[ADDR_WIDTH-1:0]] <= data_write;
        end
    end

    // Read domain
    always_comb begin
        w_ptr_rsync = PTR_W'(gray2bin(32'(w_gray_rsync)));
        r_pop       = r_ready & read & ~empty_q;
`ifdef CDC_FIFO_FWFT_EN
        // RAM is read ahead into the output register; the pointer returned to the writer
        // trails by the prefetched word so it only frees space once that word is popped.
        r_fetch  = r_ready & (w_ptr_rsync != r_ptr_q) & (~valid_q | r_pop);
        valid_d  = r_fetch | (valid_q & ~r_pop);
        r_ptr_d  = r_ptr_q + PTR_W'(r_fetch);
        r_cons_d = r_ptr_d - PTR_W'(valid_d);
`else
        r_fetch  = r_pop;
        valid_d  = r_pop;
        r_ptr_d  = r_ptr_q + PTR_W'(r_pop);
        r_cons_d = r_ptr_d;
`endif
        rd_count_d = w_ptr_rsync - r_cons_d;
    end

    always_ff @(posedge clk_read or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr_q     <= '0;
            r_gray_q    <= '0;
            rd_count_q  <= '0;
            empty_q     <= 1'b1;
            aempty_q    <= 1'b1;
            underflow_q <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            r_ptr_q     <= r_ptr_d;
            r_gray_q    <= PTR_W'(bin2gray(32'(r_cons_d)));
            rd_count_q  <= rd_count_d;
`ifdef CDC_FIFO_FWFT_EN
            empty_q     <= ~valid_d;
`else
            empty_q     <= ~r_ready | (rd_count_d == '0);
`endif
            aempty_q    <= ~r_ready | (rd_count_d <= AEMPTY_C);
            underflow_q <= r_ready & read & empty_q;
            valid_q     <= valid_d;
        end
    end

    always_ff @(posedge clk_read or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else if (r_fetch) begin
            data_q <= mem[r_ptr_q[ADDR_WIDTH-1:0]];
        end
    end

    assign full       = full_q;
    assign afull      = afull_q;
    assign overflow   = overflow_q;
    assign wr_count   = wr_count_q;
    assign empty      = empty_q;
    assign aempty     = aempty_q;
    assign underflow  = underflow_q;
    assign rd_count   = rd_count_q;
    assign valid_read = valid_q;
    assign data_read  = data_q;

endmodule

// File: tb/tb_cdc_fifo.sv
// Scoreboard-based bench for cdc_fifo: reset, fill, drain, latency, mid-traffic reset and dual-clock stress.
`timescale 1ns/100ps
module tb_cdc_fifo;

    localparam int unsigned DW  = 8;
    localparam int unsigned AW  = 4;
    localparam int unsigned SS  = 2;
    localparam int unsigned AFL = 12;
    localparam int unsigned AEL = 4;
    localparam logic [AW:0] DEPTH_C = 5'd16;

    logic          clk_write = 1'b0;
    logic          clk_read  = 1'b0;
    logic          rst_n     = 1'b1;
    logic          write     = 1'b0;
    logic [DW-1:0] data_write = '0;
    logic          read      = 1'b0;
    logic          full, afull, overflow, empty, aempty, underflow, valid_read;
    logic [AW:0]   wr_count, rd_count;
    logic [DW-1:0] data_read;

    real wr_half = 5.0;
    real rd_half = 11.5;

    always #(wr_half) clk_write = ~clk_write;
    always #(rd_half) clk_read  = ~clk_read;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned rd_got   = 0;
    logic [DW-1:0] sb [$];

    cdc_fifo #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .SYNC_STAGES (SS),
        .AFULL_LEVEL (AFL),
        .AEMPTY_LEVEL(AEL)
    ) dut (
        .clk_write (clk_write),
        .clk_read  (clk_read),
        .rst_n     (rst_n),
        .write     (write),
        .data_write(data_write),
        .full      (full),
        .afull     (afull),
        .overflow  (overflow),
        .wr_count  (wr_count),
        .read      (read),
        .data_read (data_read),
        .valid_read(valid_read),
        .empty     (empty),
        .aempty    (aempty),
        .underflow (underflow),
        .rd_count  (rd_count)
    );

    task automatic wr_cycle(input bit w, input logic [DW-1:0] d, output bit acc);
        bit f;
        @(negedge clk_write);
        write = w;
        data_write = d;
        f = full;
        @(posedge clk_write);
        #1;
        write = 1'b0;
        acc = w && !f;
        n_checks++;
        if (overflow !== (w && f)) begin
            n_fail++;
            $display("FAIL overflow: got %b expected %b", overflow, (w && f));
        end
    endtask

    task automatic rd_cycle(input bit r);
        bit e;
        logic [DW-1:0] exp_d;
        @(negedge clk_read);
        read = r;
        e = empty;
`ifdef CDC_FIFO_FWFT_EN
        n_checks++;
        if (valid_read !== !e) begin
            n_fail++;
            $display("FAIL fwft_valid: got %b expected %b", valid_read, !e);
        end
        if (r && !e) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard_empty: got data %h expected none", data_read);
            end else begin
                exp_d = sb.pop_front();
                rd_got++;
                if (data_read !== exp_d) begin
                    n_fail++;
                    $display("FAIL read_data: got %h expected %h", data_read, exp_d);
                end
            end
        end
`endif
        @(posedge clk_read);
        #1;
        read = 1'b0;
        n_checks++;
        if (underflow !== (r && e)) begin
            n_fail++;
            $display("FAIL underflow: got %b expected %b", underflow, (r && e));
        end
`ifndef CDC_FIFO_FWFT_EN
        n_checks++;
        if (valid_read !== (r && !e)) begin
            n_fail++;
            $display("FAIL valid_read: got %b expected %b", valid_read, (r && !e));
        end
        if (r && !e) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard_empty: got data %h expected none", data_read);
            end else begin
                exp_d = sb.pop_front();
                rd_got++;
                if (data_read !== exp_d) begin
                    n_fail++;
                    $display("FAIL read_data: got %h expected %h", data_read, exp_d);
                end
            end
        end
`endif
    endtask

    // Asserts reset asynchronously and checks reset values, then the post-release blocking window.
    task automatic do_reset();
        write = 1'b0;
        read  = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        n_checks++; if (full      !== 1'b0) begin n_fail++; $display("FAIL rst_full: got %b expected 0", full); end
        n_checks++; if (afull     !== 1'b0) begin n_fail++; $display("FAIL rst_afull: got %b expected 0", afull); end
        n_checks++; if (overflow  !== 1'b0) begin n_fail++; $display("FAIL rst_overflow: got %b expected 0", overflow); end
        n_checks++; if (wr_count  !== '0)   begin n_fail++; $display("FAIL rst_wr_count: got %0d expected 0", wr_count); end
        n_checks++; if (empty     !== 1'b1) begin n_fail++; $display("FAIL rst_empty: got %b expected 1", empty); end
        n_checks++; if (aempty    !== 1'b1) begin n_fail++; $display("FAIL rst_aempty: got %b expected 1", aempty); end
        n_checks++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL rst_underflow: got %b expected 0", underflow); end
        n_checks++; if (valid_read !== 1'b0) begin n_fail++; $display("FAIL rst_valid_read: got %b expected 0", valid_read); end
        n_checks++; if (rd_count  !== '0)   begin n_fail++; $display("FAIL rst_rd_count: got %0d expected 0", rd_count); end
        n_checks++; if (data_read !== '0)   begin n_fail++; $display("FAIL rst_data_read: got %h expected 00", data_read); end
        sb.delete();
        repeat (3) @(posedge clk_write);
        @(negedge clk_write);
        rst_n = 1'b1;
        @(posedge clk_write);
        #1;
        n_checks++; if (full  !== 1'b1) begin n_fail++; $display("FAIL window_full: got %b expected 1", full); end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL window_empty: got %b expected 1", empty); end
        repeat (SS + 4) @(posedge clk_write);
        repeat (SS + 4) @(posedge clk_read);
        #1;
        n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL post_reset_full: got %b expected 0", full); end
    endtask

    task automatic test_reset();
        #2;
        do_reset();
    endtask

    task automatic test_fill();
        bit acc;
        for (int i = 0; i < 16; i++) begin
            wr_cycle(1'b1, DW'(i), acc);
            sb.push_back(DW'(i));
            n_checks++; if (wr_count !== 5'(i + 1)) begin n_fail++; $display("FAIL fill_wr_count: got %0d expected %0d", wr_count, i + 1); end
            n_checks++; if (full !== (i == 15)) begin n_fail++; $display("FAIL fill_full: got %b expected %b after write %0d", full, (i == 15), i + 1); end
            n_checks++; if (afull !== (i + 1 >= int'(AFL))) begin n_fail++; $display("FAIL fill_afull: got %b expected %b after write %0d", afull, (i + 1 >= int'(AFL)), i + 1); end
        end
        wr_cycle(1'b1, 8'hFF, acc);
        n_checks++; if (wr_count !== DEPTH_C) begin n_fail++; $display("FAIL overflow_wr_count: got %0d expected 16", wr_count); end
        wr_cycle(1'b0, 8'h00, acc);
    endtask

    task automatic test_drain();
        int k;
        repeat (SS + 4) @(posedge clk_read);
        #1;
        n_checks++; if (rd_count !== DEPTH_C) begin n_fail++; $display("FAIL drain_rd_count_start: got %0d expected 16", rd_count); end
        n_checks++; if (aempty !== 1'b0) begin n_fail++; $display("FAIL drain_aempty_start: got %b expected 0", aempty); end
        for (int i = 0; i < 16; i++) begin
            rd_cycle(1'b1);
            if (i == 0) begin
                k = 0;
                while (full && k < 8) begin
                    @(posedge clk_write);
                    #1;
                    k++;
                end
                n_checks++;
                if (full || k > int'(SS) + 2) begin
                    n_fail++;
                    $display("FAIL full_release: got full=%b after %0d write edges expected 0 within %0d", full, k, SS + 2);
                end
            end
            n_checks++; if (rd_count !== 5'(15 - i)) begin n_fail++; $display("FAIL drain_rd_count: got %0d expected %0d", rd_count, 15 - i); end
            n_checks++; if (empty !== (i == 15)) begin n_fail++; $display("FAIL drain_empty: got %b expected %b", empty, (i == 15)); end
            n_checks++; if (aempty !== (15 - i <= int'(AEL))) begin n_fail++; $display("FAIL drain_aempty: got %b expected %b", aempty, (15 - i <= int'(AEL))); end
        end
        rd_cycle(1'b1);
        n_checks++; if (data_read !== 8'h0F) begin n_fail++; $display("FAIL underflow_hold: got %h expected 0f", data_read); end
    endtask

    task automatic test_latency();
        bit acc;
        int k;
        wr_cycle(1'b1, 8'hA5, acc);
        sb.push_back(8'hA5);
        k = 0;
        while (empty && k < 8) begin
            @(posedge clk_read);
            #1;
            k++;
        end
        n_checks++;
        if (empty || k > int'(SS) + 2) begin
            n_fail++;
            $display("FAIL latency: got empty=%b after %0d read edges expected 0 within %0d", empty, k, SS + 2);
        end
`ifdef CDC_FIFO_FWFT_EN
        n_checks++; if (data_read !== 8'hA5) begin n_fail++; $display("FAIL fwft_prefetch: got %h expected a5", data_read); end
`endif
        rd_cycle(1'b1);
    endtask

    task automatic test_reset_mid();
        bit acc;
        int k;
        for (int i = 0; i < 5; i++) begin
            wr_cycle(1'b1, DW'(8'h40 + i), acc);
            sb.push_back(DW'(8'h40 + i));
        end
        repeat (SS + 4) @(posedge clk_read);
        rd_cycle(1'b1);
        rd_cycle(1'b1);
        do_reset();
        wr_cycle(1'b1, 8'h11, acc);
        sb.push_back(8'h11);
        k = 0;
        while (empty && k < 8) begin
            @(posedge clk_read);
            #1;
            k++;
        end
        n_checks++; if (empty) begin n_fail++; $display("FAIL reset_mid_visible: got empty=%b expected 0", empty); end
        rd_cycle(1'b1);
        n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL reset_mid_first: got %0d words left expected 0", sb.size()); end
    endtask

    task automatic test_stress(input real wh, input real rh, input int unsigned nwords);
        int unsigned sent;
        wr_half = wh;
        rd_half = rh;
        do_reset();
        rd_got = 0;
        sent = 0;
        fork
            begin
                int unsigned wc;
                bit w;
                bit acc;
                logic [DW-1:0] d;
                wc = 0;
                while (sent < nwords && wc < 20000) begin
                    w = ($urandom_range(0, 99) < 60);
                    d = DW'($urandom);
                    wr_cycle(w, d, acc);
                    if (acc) begin
                        sb.push_back(d);
                        sent++;
                    end
                    n_checks++;
                    if (wr_count > DEPTH_C) begin n_fail++; $display("FAIL stress_wr_count: got %0d expected <= 16", wr_count); end
                    wc++;
                end
            end
            begin
                int unsigned rc;
                rc = 0;
                while (rd_got < nwords && rc < 20000) begin
                    rd_cycle($urandom_range(0, 99) < 60);
                    n_checks++;
                    if (rd_count > DEPTH_C) begin n_fail++; $display("FAIL stress_rd_count: got %0d expected <= 16", rd_count); end
                    rc++;
                end
            end
        join
        n_checks++; if (sent != nwords) begin n_fail++; $display("FAIL stress_sent: got %0d expected %0d", sent, nwords); end
        n_checks++; if (rd_got != nwords) begin n_fail++; $display("FAIL stress_received: got %0d expected %0d", rd_got, nwords); end
        n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL stress_leftover: got %0d expected 0", sb.size()); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_latency();
        test_reset_mid();
        test_stress(5.0, 11.5, 1000);
        test_stress(11.5, 5.0, 1000);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cdc_fifo.md
CDC_FIFO -- requirements
Module: cdc_fifo

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, word width in bits.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 13, with depth DEPTH = 2**ADDR_WIDTH words.
REQ-003 The block SHALL have parameter SYNC_STAGES, default 2, legal 2..4, flops per pointer synchroniser.
REQ-004 The block SHALL have parameter AFULL_LEVEL, default DEPTH-4, the almost-full threshold in words.
REQ-005 The block SHALL have parameter AEMPTY_LEVEL, default 4, the almost-empty threshold in words.
REQ-006 The block SHALL have port clk_write, input, 1 bit, write-domain clock.
REQ-007 The block SHALL have port clk_read, input, 1 bit, read-domain clock.
REQ-008 The block SHALL have port rst_n, input, 1 bit, reset: asynchronous, active-low; clock clk_write, and applied to both domains.
REQ-009 The block SHALL have ports write input 1 and data_write input DATA_WIDTH: push request and data.
REQ-010 The block SHALL have ports full, afull and overflow, each output 1, in the write domain.
REQ-011 The block SHALL have port wr_count, output ADDR_WIDTH+1, occupancy seen by the write domain.
REQ-012 The block SHALL have ports read input 1, data_read output DATA_WIDTH and valid_read output 1, in the read domain.
REQ-013 The block SHALL have ports empty, aempty and underflow, each output 1, and port rd_count, output ADDR_WIDTH+1, in the read domain.

Function
REQ-014 A write SHALL be accepted when write=1 and full=0; the word is stored and the write pointer increments at that clk_write edge.
REQ-015 write=1 while full=1 SHALL drop the word, leave state unchanged and pulse overflow for one clk_write cycle.
REQ-016 full SHALL be registered and look-ahead: it asserts on the edge that accepts the DEPTH-th word, with no extra cycle of latency.
REQ-017 Pointers SHALL be ADDR_WIDTH+1-bit binary counters that wrap modulo 2**(ADDR_WIDTH+1) and cross domains only as Gray code through SYNC_STAGES flops.
REQ-018 wr_count SHALL equal (w_ptr - r_ptr_sync) mod 2**(ADDR_WIDTH+1), with range 0..DEPTH inclusive (DEPTH when full).
REQ-019 rd_count SHALL equal (w_ptr_sync - r_ptr) mod 2**(ADDR_WIDTH+1), computed in the read domain from read-domain signals only.
REQ-020 afull SHALL be 1 iff wr_count >= AFULL_LEVEL, and aempty SHALL be 1 iff rd_count <= AEMPTY_LEVEL, both registered.
REQ-021 In standard mode, a read with read=1 and empty=0 SHALL present the head word on data_read with valid_read=1 exactly one clk_read cycle later; otherwise data_read SHALL hold and valid_read SHALL be 0.
REQ-022 read=1 while empty=1 SHALL leave state unchanged and pulse underflow for one clk_read cycle.
REQ-023 empty SHALL be registered and look-ahead: it asserts on the edge that pops the last visible word.
REQ-024 A write SHALL be visible to the reader (empty deasserts) no later than SYNC_STAGES+2 clk_read edges after the accepting clk_write edge; a read SHALL free space (full deasserts) no later than SYNC_STAGES+2 clk_write edges after it.
REQ-025 Simultaneous write and read at any occupancy SHALL both complete, with ordering strictly FIFO and no loss or duplication.

Reset
REQ-026 rst_n low SHALL asynchronously clear pointers, synchronisers and counts; full=0, afull=0, overflow=0, wr_count=0, empty=1, aempty=1, underflow=0, valid_read=0, rd_count=0 and data_read=0.
REQ-027 Reset release SHALL be synchronised separately into each domain by a SYNC_STAGES-flop synchroniser; accesses in the first SYNC_STAGES cycles after release SHALL be ignored, with full=1 in the write domain and empty=1 in the read domain during that window.
REQ-028 Reset asserted mid-transfer SHALL discard all contents; there is no partial-state retention.

Configuration
REQ-029 With macro CDC_FIFO_FWFT_EN defined, the block SHALL operate in first-word-fall-through mode: the head word is prefetched into the output register, empty=0 means data_read is already valid (valid_read=~empty), read pops it, and rd_count includes the prefetched word.
REQ-030 Without CDC_FIFO_FWFT_EN, the block SHALL operate in standard mode per REQ-021, with no prefetch logic present.

Structure
REQ-031 Package cdc_fifo_pkg SHALL hold the bin2gray and gray2bin functions and the default parameter constants.
REQ-032 Sub-module cdc_sync_bus, a parametrised SYNC_STAGES-deep multi-bit flop synchroniser, SHALL be used for both pointers and both reset releases.
REQ-033 Storage SHALL be a simple dual-port RAM inferred inline, with the write port on clk_write and a registered read on clk_read.

Verification (DATA_WIDTH=8, ADDR_WIDTH=4, SYNC_STAGES=2, AFULL_LEVEL=12, AEMPTY_LEVEL=4)
REQ-034 Reset: pulse rst_n low mid-traffic -> all outputs take their REQ-026 values immediately, and a subsequent write of 0x11 reads back as the first word.
REQ-035 Fill: write 0x00..0x0F with clk_read idle -> full=1 on the 16th edge and wr_count=16; afull=1 after the 12th write; a 17th write of 0xFF pulses overflow and is not stored.
REQ-036 Drain: read 16 times -> data 0x00..0x0F in order; empty=1 on the last pop; a 17th read pulses underflow and data_read holds 0x0F.
REQ-037 Latency: write 0xA5 into an empty FIFO -> empty falls within 4 clk_read edges; in FWFT mode data_read=0xA5 with no read issued.
REQ-038 Stress: clk_write 10 ns, clk_read 23 ns (then swapped), 1000 random words with random write/read -> scoreboard matches in order, pointers wrap at least 30 times, wr_count and rd_count never exceed 16.
